// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter and its scoreboard.
package rf_wb_arbiter_pkg;
   localparam int REG_ZERO   = 0;
   localparam int DEFAULT_AW = 5;
   localparam int DEFAULT_DW = 32;
   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending bits for long-latency destinations, with two decode stall read ports.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
#(
   parameter int AW = DEFAULT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sb_set,
   input  logic [AW-1:0] sb_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd_a1,
   input  logic [AW-1:0] rd_a2,
   output logic          stall,
   output logic          sb_conflict
);
   localparam int NREG = 2 ** AW;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            set_en;

   assign set_en = sb_set && (sb_addr != AW'(REG_ZERO));

   // Register 0 is hardwired to zero and can never be pending.
   assign busy_next[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
         // Set has priority over the commit clear on the same register.
         assign busy_next[gi] = (set_en && (sb_addr == AW'(gi))) ? 1'b1 :
                                (clr_en && (clr_addr == AW'(gi))) ? 1'b0 : busy[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy        <= '0;
         sb_conflict <= 1'b0;
      end else begin
         busy        <= busy_next;
         sb_conflict <= set_en && busy[sb_addr];
      end
   end

   assign stall = busy[rd_a1] || busy[rd_a2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter driving the register file write port from a registered stage.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int AW        = DEFAULT_AW,
   parameter int DW        = DEFAULT_DW,
   parameter int PRIO_MODE = PRIO_RR
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   input  logic          sb_set,
   input  logic [AW-1:0] sb_addr,
   input  logic [AW-1:0] rd_a1,
   input  logic [AW-1:0] rd_a2,
   output logic          stall,
   output logic [AW-1:0] rf_a3,
   output logic [DW-1:0] rf_wd,
   output logic          rf_wr,
   output logic          sb_conflict
);
   logic          last_grant;  // 1 = req1 won the most recent transfer
   logic          xfer0;
   logic          xfer1;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;
   logic          commit;

   // Ready is a function of the valids and history only, never of addr/data.
   assign req0_ready = req0_valid &&
                       (!req1_valid || (PRIO_MODE == PRIO_FIXED) || last_grant);
   assign req1_ready = req1_valid && !req0_ready;

   assign xfer0    = req0_valid && req0_ready;
   assign xfer1    = req1_valid && req1_ready;
   assign win_addr = xfer0 ? req0_addr : req1_addr;
   assign win_data = xfer0 ? req0_data : req1_data;
   assign commit   = (xfer0 || xfer1) && (win_addr != AW'(REG_ZERO));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wr      <= 1'b0;
         rf_a3      <= '0;
         rf_wd      <= '0;
         last_grant <= 1'b1;
      end else begin
         rf_wr <= commit;
         if (commit) begin
            rf_a3 <= win_addr;
            rf_wd <= win_data;
         end
         if (xfer0 || xfer1) begin
            last_grant <= xfer1;
         end
      end
   end

   rf_scoreboard #(.AW(AW)) u_sb (
      .clk         (clk),
      .rst         (rst),
      .sb_set      (sb_set),
      .sb_addr     (sb_addr),
      .clr_en      (rf_wr),
      .clr_addr    (rf_a3),
      .rd_a1       (rd_a1),
      .rd_a2       (rd_a2),
      .stall       (stall),
      .sb_conflict (sb_conflict)
   );
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: req0 (ALU/execute write-back) and req1 (long-latency unit, e.g. load or multiply/divide).
- Drives the register file write port (A3/WD/RFWr) from a registered output stage.
- Keeps a per-register pending scoreboard so decode stalls on reads of registers that a long-latency op has yet to write.
- Sits between the execute/memory stages and the 32x32 register file.

Parameters:
- AW, 5: register address width; NREG = 2**AW entries.
- DW, 32: write data width.
- PRIO_MODE, 0: 0 = round-robin between req0 and req1; 1 = fixed priority, req0 always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst==0 resets immediately.
- req0_valid  in  1  ALU write-back request.
- req0_ready  out  1  grant to req0 this cycle; combinational.
- req0_addr  in  AW  destination register for req0.
- req0_data  in  DW  write data for req0.
- req1_valid  in  1  long-latency write-back request.
- req1_ready  out  1  grant to req1 this cycle; combinational.
- req1_addr  in  AW  destination register for req1.
- req1_data  in  DW  write data for req1.
- sb_set  in  1  a long-latency op issues this cycle; marks sb_addr pending.
- sb_addr  in  AW  destination register of the issuing op.
- rd_a1  in  AW  decode read address 1.
- rd_a2  in  AW  decode read address 2.
- stall  out  1  rd_a1 or rd_a2 is pending; combinational.
- rf_a3  out  AW  register file write address; registered.
- rf_wd  out  DW  register file write data; registered.
- rf_wr  out  1  register file write enable; registered.
- sb_conflict  out  1  one-cycle pulse: sb_set targeted a register that was already pending.

Behaviour:
- Reset values: rf_wr=0, rf_a3=0, rf_wd=0, sb_conflict=0, all busy bits=0, last_grant=1 (so req0 wins first contention).
- Handshake:
  - A transfer occurs when valid&&ready at a rising edge.
  - Once a requester asserts valid, it holds addr and data stable until ready.
  - Ready never depends on the same requester's addr or data.
- Arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid, PRIO_MODE=0: grant the requester not in last_grant.
  - Both valid, PRIO_MODE=1: grant req0.
  - last_grant updates only on a transfer.
- Output stage:
  - Transfer at edge E loads rf_a3/rf_wd and sets rf_wr=1 for the cycle after E; the register file writes at edge E+1.
  - With no transfer at E, rf_wr=0 after E.
  - Sustains one write per cycle with no bubbles; the register file never back-pressures.
- Register 0:
  - A transfer with addr 0 is accepted (ready as normal), but rf_wr stays 0 and the scoreboard is untouched.
  - sb_set with sb_addr=0 is ignored, including sb_conflict.
- Scoreboard:
  - busy[r] sets at the edge where sb_set=1 and sb_addr=r.
  - busy[r] clears at the edge where rf_wr=1 and rf_a3=r (the write commit).
  - Set and clear on the same r at the same edge: set wins and busy stays 1.
  - sb_set on an already-busy r: busy stays 1 and sb_conflict=1 for the next cycle.
- Stall:
  - stall = (rd_a1!=0 && busy[rd_a1]) || (rd_a2!=0 && busy[rd_a2]).
  - stall stays high through the cycle rf_wr is asserted for that register, and falls the cycle after the commit.
  - There is no bypass.
- Reset mid-operation:
  - In-flight output writes are dropped (rf_wr=0).
  - All pending bits clear.
  - Requesters re-present their requests after reset.
- Latency: request accepted at edge E; data visible on register file reads from cycle E+2.

Decomposition:
- Shared package holds:
  - REG_ZERO = 0.
  - Default AW and DW.
  - PRIO_RR and PRIO_FIXED encodings.
- One natural sub-module: rf_scoreboard. It holds the busy vector, set/clear/conflict logic and the two stall read ports.
- The arbiter and output stage stay in the top module.

Test Plan:
- Reset then req0_valid=1, addr=5, data=0x1234: req0_ready=1 same cycle; next cycle rf_wr=1, rf_a3=5, rf_wd=0x1234; following cycle rf_wr=0.
- Both valid every cycle for 4 cycles, PRIO_MODE=0 (req0 addr 3, req1 addr 7): grants alternate 0,1,0,1. With PRIO_MODE=1, req0 wins all 4 and req1_ready stays 0.
- sb_set, sb_addr=9, then rd_a1=9: stall=1 the cycle after set. req1 writes 9: stall stays 1 while rf_wr asserted, then 0 the cycle after.
- req0 addr=0, data=0xFFFF_FFFF: req0_ready=1, rf_wr remains 0. sb_set with sb_addr=0: no stall on rd_a1=0 and sb_conflict=0.
- sb_set addr 4 twice on consecutive edges: sb_conflict pulses 1 for one cycle. sb_set addr 4 coincident with rf_wr commit to 4: busy[4] remains 1.
- rst=0 asserted asynchronously mid-cycle while rf_wr=1 and busy[2]=1: rf_wr drops immediately, stall on rd_a1=2 goes 0, rf_a3 and rf_wd read 0.
